mod3221_mul_seq: RTL

Sequential modular multiplier for the 3221 prime field: accepts two 12-bit residues over a valid/ready handshake and returns (a·b) mod 3221 after a fixed bit-serial computation. It produces the reduced residues that the Barrett reduction datapath and its checkers consume. Reduction is interleaved one operand bit per cycle, so no wide 23/24-bit product is ever formed. It is the streaming, handshaked producer side of the existing combinational reduction path.

---
 rtl/mod3221_mul_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mod3221_mul_seq.sv
// mod3221_mul_seq: bit-serial modular multiplier, result = (a*b) mod Q.
// One multiplier bit (MSB first) is folded into the accumulator per cycle and
// reduced immediately, so no double-width product is ever formed.
// Optional feature macro: MOD3221_RANGE_CHECK_EN. When it is defined,
// out-of-range operands skip RUN and complete at once with err=1 and result=0.
module mod3221_mul_seq #(
   parameter int unsigned Q  = 3221,
   parameter int unsigned QW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] a,
   input  logic [QW-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] result,
   output logic          busy,
   output logic          err
);

   localparam int unsigned TW = QW + 2;
   localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [TW-1:0] Q1 = TW'(Q);
   localparam logic [TW-1:0] Q2 = TW'(2 * Q);
   localparam logic [QW-1:0] QV = QW'(Q);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [QW-1:0] a_q, a_d;
   logic [QW-1:0] b_q, b_d;
   logic [QW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [QW-1:0] result_q, result_d;
   logic          err_q, err_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;

   logic [TW-1:0] addend_c;
   logic [TW-1:0] t_c;
   logic [QW-1:0] acc_next_c;
   logic          range_bad_c;

   // One interleaved step: t = 2*acc + (b[cnt] ? a : 0), then subtract 0, Q or 2Q.
   always_comb begin
      addend_c   = b_q[cnt_q] ? TW'(a_q) : '0;
      t_c        = TW'({acc_q, 1'b0}) + addend_c;
      acc_next_c = QW'(t_c);
      if (t_c >= Q2) begin
         acc_next_c = QW'(t_c - Q2);
      end else if (t_c >= Q1) begin
         acc_next_c = QW'(t_c - Q1);
      end
   end

   // Operand range flag; constant zero unless the range check is built in.
   always_comb begin
`ifdef MOD3221_RANGE_CHECK_EN
      range_bad_c = (a >= QV) || (b >= QV);
`else
      range_bad_c = 1'b0;
`endif
   end

   // Next-state and datapath updates; registered outputs follow the next state.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d   = a;
               b_d   = b;
               acc_d = '0;
               cnt_d = CW'(QW - 1);
               if (range_bad_c) begin
                  state_d  = S_DONE;
                  result_d = '0;
                  err_d    = 1'b1;
               end else begin
                  state_d = S_RUN;
                  err_d   = 1'b0;
               end
            end
         end
         S_RUN: begin
            acc_d = acc_next_c;
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               result_d = acc_next_c;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
